hazard_ctrl: RTL and testbench

Pipeline sequencer for the five-stage MIPS core. It drives the hold and clear controls of the IF/ID and ID/EX pipeline registers, and the clear control of EX/MEM. It owns the multi-cycle multiply/divide busy sequencer. It resolves priority between load-use stalls, HI/LO interlocks and MEM-stage exception/ERET redirects.

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use and HI/LO interlocks, MEM-stage redirects,
// and the multi-cycle multiply/divide busy tracker.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        use_rs_d,
    input  logic        use_rt_d,
    input  logic        md_use_d,
    input  logic        load_e,
    input  logic [4:0]  rwa_e,
    input  logic        md_start_e,
    input  logic        md_div_e,
    input  logic        exc_m,
    input  logic        eret_m,
    output logic        stall_f,
    output logic        stall_d,
    output logic        bubble_e,
    output logic        flush_all,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    localparam logic [1:0] PC_SEQ     = 2'b00;
    localparam logic [1:0] PC_HANDLER = 2'b01;
    localparam logic [1:0] PC_EPC     = 2'b10;

    md_state_t  state;
    logic [4:0] cnt;
    logic       lu;
    logic       mdh;
    logic       redirect;

    assign md_busy  = (state == BUSY);
    assign md_done  = (state == BUSY) && (cnt == 5'd1);
    assign redirect = exc_m | eret_m;

    // Register $0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        lu  = 1'b0;
        mdh = 1'b0;
        if (load_e && (rwa_e != 5'd0)) begin
            lu = (use_rs_d && (rs_d == rwa_e)) || (use_rt_d && (rt_d == rwa_e));
        end
        mdh = md_use_d && (md_busy || md_start_e);
    end

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        bubble_e  = 1'b0;
        flush_all = 1'b0;
        pc_sel    = PC_SEQ;
        if (exc_m) begin
            flush_all = 1'b1;
            pc_sel    = PC_HANDLER;
        end else if (eret_m) begin
            flush_all = 1'b1;
            pc_sel    = PC_EPC;
        end else if (lu || mdh) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
        end
    end

    // A start coinciding with a redirect belongs to a flushed EX slot; a start seen
    // while BUSY is ignored, and redirects never abort a committed operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_e && !redirect) begin
                        state <= BUSY;
                        cnt   <= md_div_e ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 32'd0;
        end else if (stall_d) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, $0 target, mult/div sequencing,
// redirect priority and asynchronous reset mid-operation.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic        use_rs_d;
    logic        use_rt_d;
    logic        md_use_d;
    logic        load_e;
    logic [4:0]  rwa_e;
    logic        md_start_e;
    logic        md_div_e;
    logic        exc_m;
    logic        eret_m;
    logic        stall_f;
    logic        stall_d;
    logic        bubble_e;
    logic        flush_all;
    logic [1:0]  pc_sel;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .use_rs_d    (use_rs_d),
        .use_rt_d    (use_rt_d),
        .md_use_d    (md_use_d),
        .load_e      (load_e),
        .rwa_e       (rwa_e),
        .md_start_e  (md_start_e),
        .md_div_e    (md_div_e),
        .exc_m       (exc_m),
        .eret_m      (eret_m),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .bubble_e    (bubble_e),
        .flush_all   (flush_all),
        .pc_sel      (pc_sel),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_d = 5'd0; rt_d = 5'd0; use_rs_d = 1'b0; use_rt_d = 1'b0;
        md_use_d = 1'b0; load_e = 1'b0; rwa_e = 5'd0;
        md_start_e = 1'b0; md_div_e = 1'b0; exc_m = 1'b0; eret_m = 1'b0;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stall_f"}, {31'd0, stall_f}, {31'd0, exp});
        chk({tag, "_stall_d"}, {31'd0, stall_d}, {31'd0, exp});
        chk({tag, "_bubble_e"}, {31'd0, bubble_e}, {31'd0, exp});
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #3;
        // Reset state
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_done", {31'd0, md_done}, 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);
        chk("rst_flush", {31'd0, flush_all}, 32'd0);
        chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
        chk_stall("rst_idle", 1'b0);
        // Combinational outputs follow inputs during reset, but the counter is held
        load_e = 1'b1; rwa_e = 5'd8; use_rs_d = 1'b1; rs_d = 5'd8;
        #1;
        chk_stall("rst_lu", 1'b1);
        step();
        chk("rst_cnt_held", stall_cycles, 32'd0);
        clear_inputs();
        reset = 1'b1;
        #1;

        // Load-use on rs: one stall cycle
        load_e = 1'b1; rwa_e = 5'd8; use_rs_d = 1'b1; rs_d = 5'd8;
        #1;
        chk_stall("lu_rs", 1'b1);
        chk("lu_pc_sel", {30'd0, pc_sel}, 32'd0);
        chk("lu_flush", {31'd0, flush_all}, 32'd0);
        step();
        clear_inputs();
        #1;
        chk_stall("lu_after", 1'b0);
        chk("lu_cnt", stall_cycles, 32'd1);

        // rt path and non-matching operands
        load_e = 1'b1; rwa_e = 5'd9; use_rt_d = 1'b1; rt_d = 5'd9;
        #1;
        chk_stall("lu_rt", 1'b1);
        rt_d = 5'd10;
        #1;
        chk_stall("lu_rt_miss", 1'b0);
        rt_d = 5'd9; use_rt_d = 1'b0;
        #1;
        chk_stall("lu_rt_unused", 1'b0);
        clear_inputs();

        // $0 destination never stalls
        load_e = 1'b1; rwa_e = 5'd0; rs_d = 5'd0; use_rs_d = 1'b1;
        #1;
        chk_stall("zero_dst", 1'b0);
        step();
        clear_inputs();
        chk("zero_cnt", stall_cycles, 32'd1);

        // mult in EX, mflo in ID: 6 stall cycles, 5 busy, done on the 5th
        md_start_e = 1'b1; md_div_e = 1'b0; md_use_d = 1'b1;
        #1;
        chk_stall("mult_start", 1'b1);
        chk("mult_start_busy", {31'd0, md_busy}, 32'd0);
        step();
        md_start_e = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("mult_busy%0d", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("mult_done%0d", k), {31'd0, md_done}, (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("mult_stall%0d", k), {31'd0, stall_d}, 32'd1);
            step();
        end
        #1;
        chk("mult_idle", {31'd0, md_busy}, 32'd0);
        chk("mult_release", {31'd0, stall_d}, 32'd0);
        chk("mult_cnt", stall_cycles, 32'd7);
        clear_inputs();

        // div: 10 busy cycles, no consumer in ID
        md_start_e = 1'b1; md_div_e = 1'b1;
        #1;
        chk("div_start_stall", {31'd0, stall_d}, 32'd0);
        step();
        md_start_e = 1'b0; md_div_e = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk($sformatf("div_busy%0d", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("div_done%0d", k), {31'd0, md_done}, (k == 10) ? 32'd1 : 32'd0);
            step();
        end
        chk("div_idle", {31'd0, md_busy}, 32'd0);
        chk("div_done_low", {31'd0, md_done}, 32'd0);
        chk("div_cnt", stall_cycles, 32'd7);

        // Exception beats load-use and discards the EX start
        load_e = 1'b1; rwa_e = 5'd8; rs_d = 5'd8; use_rs_d = 1'b1;
        md_start_e = 1'b1; exc_m = 1'b1;
        #1;
        chk("exc_flush", {31'd0, flush_all}, 32'd1);
        chk("exc_pc_sel", {30'd0, pc_sel}, 32'd1);
        chk_stall("exc", 1'b0);
        eret_m = 1'b1;
        #1;
        chk("exc_over_eret", {30'd0, pc_sel}, 32'd1);
        step();
        clear_inputs();
        #1;
        chk("exc_md_idle", {31'd0, md_busy}, 32'd0);
        chk("exc_cnt", stall_cycles, 32'd7);

        // ERET mid-busy redirects without aborting the operation
        md_start_e = 1'b1;
        step();
        md_start_e = 1'b0;
        step();
        eret_m = 1'b1; md_use_d = 1'b1;
        #1;
        chk("eret_pc_sel", {30'd0, pc_sel}, 32'd2);
        chk("eret_flush", {31'd0, flush_all}, 32'd1);
        chk_stall("eret", 1'b0);
        chk("eret_busy", {31'd0, md_busy}, 32'd1);
        step();
        clear_inputs();
        #1;
        chk("eret_still_busy", {31'd0, md_busy}, 32'd1);
        chk("eret_cnt", stall_cycles, 32'd7);

        // Asynchronous reset mid-busy
        #1;
        reset = 1'b0;
        #1;
        chk("areset_busy", {31'd0, md_busy}, 32'd0);
        chk("areset_done", {31'd0, md_done}, 32'd0);
        chk("areset_cnt", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
